// File: rtl/nonce_sweeper_if.sv
// Header offer / hash return channel between the nonce sweeper and the SHA256d core.
// The sweeper is the master: it offers headers and consumes hash results.
interface nonce_sweeper_if;
   logic         hdr_valid;
   logic         hdr_ready;
   logic [639:0] header;
   logic         hash_valid;
   logic [255:0] hash;

   modport master (
      output hdr_valid,
      output header,
      input  hdr_ready,
      input  hash_valid,
      input  hash
   );

   modport slave (
      input  hdr_valid,
      input  header,
      output hdr_ready,
      output hash_valid,
      output hash
   );
endinterface

// File: rtl/nonce_sweeper.sv
// Sweeps an inclusive, wrapping nonce range through the hash core and stops on
// the first hash at or below target, on range exhaustion, timeout or abort.
module nonce_sweeper #(
   parameter int unsigned NONCE_STEP     = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [607:0]          template,
   input  logic [255:0]          target,
   input  logic [31:0]           nonce_start,
   input  logic [31:0]           nonce_end,
   nonce_sweeper_if.master       core,
   output logic                  busy,
   output logic                  done,
   output logic                  found,
   output logic                  timeout,
   output logic [31:0]           nonce_found,
   output logic [255:0]          hash_found,
   output logic [31:0]           attempts
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]   STEP      = 32'(NONCE_STEP);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} state_t;

   state_t         state;
   logic [607:0]   tmpl_r;
   logic [255:0]   target_r;
   logic [31:0]    nonce;
   logic [31:0]    nonce_end_r;
   logic [255:0]   hash_p1;
   logic [TW-1:0]  timer;
   logic [31:0]    rem;
   logic [31:0]    nonce_nx;

   function automatic logic [31:0] bswap32(input logic [31:0] n);
      return {n[7:0], n[15:8], n[23:16], n[31:24]};
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Distance to the inclusive end, modulo 2^32, so wrapping ranges terminate correctly.
   assign rem      = nonce_end_r - nonce;
   assign nonce_nx = nonce + STEP;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         core.hdr_valid <= 1'b0;
         core.header    <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         found          <= 1'b0;
         timeout        <= 1'b0;
         nonce_found    <= '0;
         hash_found     <= '0;
         attempts       <= '0;
         timer          <= '0;
      end else if (abort && state != IDLE) begin
         state          <= IDLE;
         core.hdr_valid <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  tmpl_r         <= template;
                  target_r       <= target;
                  nonce          <= nonce_start;
                  nonce_end_r    <= nonce_end;
                  attempts       <= '0;
                  found          <= 1'b0;
                  timeout        <= 1'b0;
                  core.header    <= {template, bswap32(nonce_start)};
                  core.hdr_valid <= 1'b1;
                  busy           <= 1'b1;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               if (core.hdr_ready) begin
                  core.hdr_valid <= 1'b0;
                  timer          <= '0;
                  state          <= WAIT;
               end
            end
            WAIT: begin
               if (core.hash_valid) begin
                  hash_p1 <= core.hash;
                  state   <= CHECK;
               end else if (timer == TIMER_MAX) begin
                  timeout <= 1'b1;
                  done    <= 1'b1;
                  state   <= DONE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            // ---- CHECK: compare registered hash, then stop or advance ----
            CHECK: begin
               attempts <= sat_inc32(attempts);
               if (hash_p1 <= target_r) begin
                  found       <= 1'b1;
                  nonce_found <= nonce;
                  hash_found  <= hash_p1;
                  done        <= 1'b1;
                  state       <= DONE;
               end else if (rem < STEP) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  nonce          <= nonce_nx;
                  core.header    <= {tmpl_r, bswap32(nonce_nx)};
                  core.hdr_valid <= 1'b1;
                  state          <= ISSUE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
